// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//   Instruction-fetch front end. Owns the fetch address and issues word reads
//   to instruction memory over a req/gnt + in-order rvalid interface. Returned
//   words are buffered with their PCs in a DEPTH-entry FIFO and presented to
//   decode over valid/ready. A redirect loads a new fetch address, flushes the
//   queue and arranges for every read still in flight to be dropped on return.
//
//   Optional feature macro: IFQ_BYPASS_EN
//     defined   : a response arriving while the queue is empty (and nothing is
//                 being discarded) is presented to decode in the same cycle and
//                 consumed without a push if decode is ready.
//     undefined : every response passes through the FIFO; head outputs are
//                 driven only from registered state.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   redirect_valid  load redirect_addr as the new fetch address this cycle
//   redirect_addr   new word address
//   mem_req         read request
//   mem_addr        word address of the request
//   mem_gnt         request accepted this cycle
//   mem_rvalid      read data valid (responses return in request order)
//   mem_rdata       read data
//   inst_valid      queue head valid
//   inst_data       queue head instruction
//   inst_pc         word address of inst_data
//   inst_ready      decode accepts the head
// ----------------------------------------------------------------------------
module ifetch_queue #(
   parameter int DEPTH = 4,   // power of 2, >= 2; also the read-credit limit
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_addr,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic          inst_valid,
   output logic [DW-1:0] inst_data,
   output logic [AW-1:0] inst_pc,
   input  logic          inst_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] fetch_pc;
   logic [AW-1:0] resp_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   logic [AW-1:0] fifo_pc   [DEPTH];
   logic [DW-1:0] fifo_data [DEPTH];

   logic [CW:0]   credit_used;
   logic          live;
   logic          fifo_valid;
   logic          grant;
   logic          accept;
   logic          bypass_take;
   logic          push;
   logic          pop;

   // Updates other than reset/redirect only happen on a normal working cycle.
   assign live       = reset && !redirect_valid;
   assign fifo_valid = (count != '0);

   // A request is only made when a FIFO slot is guaranteed for its response:
   // in-flight reads plus buffered words never exceed DEPTH.
   assign credit_used = {1'b0, outstanding} + {1'b0, count};
   assign mem_req     = live && (credit_used < (CW+1)'(DEPTH));
   assign mem_addr    = fetch_pc;
   assign grant       = mem_req && mem_gnt;

   // A response is kept only when no stale reads remain to be dropped.
   assign accept = live && mem_rvalid && (discard == '0);

`ifdef IFQ_BYPASS_EN
   logic bypass;

   assign bypass      = accept && !fifo_valid;
   assign inst_valid  = fifo_valid || bypass;
   assign inst_data   = fifo_valid ? fifo_data[rd_ptr] : (bypass ? mem_rdata : '0);
   assign inst_pc     = fifo_valid ? fifo_pc[rd_ptr]   : (bypass ? resp_pc   : '0);
   assign bypass_take = bypass && inst_ready;
`else
   assign inst_valid  = fifo_valid;
   assign inst_data   = fifo_valid ? fifo_data[rd_ptr] : '0;
   assign inst_pc     = fifo_valid ? fifo_pc[rd_ptr]   : '0;
   assign bypass_take = 1'b0;
`endif

   assign push = accept && !bypass_take;
   assign pop  = live && fifo_valid && inst_ready;

   // NOTE: every sequential process uses non-blocking assignments so that all
   // registers sample the same pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc    <= '0;
         resp_pc     <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else if (redirect_valid) begin
         // No grant is possible this cycle (mem_req is low), so the reads still
         // owed after this edge are the current ones minus any returning now;
         // all of them belong to the old stream and must be dropped.
         fetch_pc    <= redirect_addr;
         resp_pc     <= redirect_addr;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= outstanding - CW'(mem_rvalid);
         discard     <= outstanding - CW'(mem_rvalid);
      end else begin
         if (grant) begin
            fetch_pc <= fetch_pc + AW'(1);
         end
         outstanding <= outstanding + CW'(grant) - CW'(mem_rvalid);
         if (mem_rvalid && (discard != '0)) begin
            discard <= discard - CW'(1);
         end
         if (accept) begin
            resp_pc <= resp_pc + AW'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // NOTE: the storage array has no reset; the head outputs are forced to zero
   // while the queue is empty, so stale or uninitialised entries never leak.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= resp_pc;
         fifo_data[wr_ptr] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_queue
//   Directed bench for ifetch_queue. A small in-order memory model answers each
//   granted read one or more cycles later with data = addr ^ 32'hA5A5_0000.
//   Inputs change just after each rising edge; outputs are sampled 1 ns later
//   or 1 ns before the next edge.
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam logic [31:0] XMASK = 32'hA5A5_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          redirect_valid;
   logic [AW-1:0] redirect_addr;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic          inst_valid;
   logic [DW-1:0] inst_data;
   logic [AW-1:0] inst_pc;
   logic          inst_ready;

   ifetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_gnt        (mem_gnt),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] pend[$];     // granted reads awaiting a response
   logic [31:0] gnt_log[$];  // addresses of granted reads
   logic [63:0] pop_q[$];    // {pc, data} of every word decode accepted
   bit          gnt_en;
   bit          rv_en;
   logic        s_req;       // pre-edge samples from the last step
   logic        s_valid;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive memory-model inputs, sample pre-edge, clock, update model.
   task automatic step();
      logic        fire_g;
      logic        fire_r;
      logic [31:0] a;
      mem_gnt    = gnt_en;
      mem_rvalid = rv_en && (pend.size() != 0);
      mem_rdata  = '0;
      if (mem_rvalid) mem_rdata = pend[0] ^ XMASK;
      #1;
      s_req   = mem_req;
      s_valid = inst_valid;
      fire_g  = (mem_req === 1'b1) && mem_gnt;
      fire_r  = mem_rvalid;
      a       = mem_addr;
      if ((inst_valid === 1'b1) && inst_ready && !redirect_valid && reset)
         pop_q.push_back({inst_pc, inst_data});
      @(posedge clk);
      if (fire_r) void'(pend.pop_front());
      if (fire_g) begin
         pend.push_back(a);
         gnt_log.push_back(a);
      end
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      mem_gnt        = 1'b1;
      mem_rvalid     = 1'b0;
      mem_rdata      = '0;
      inst_ready     = 1'b0;
      gnt_en         = 1'b1;
      rv_en          = 1'b0;
      @(posedge clk);
      #1;

      // ---- 1: reset held with gnt high ----
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_req",   {63'd0, mem_req},    64'd0);
         check("rst_valid", {63'd0, inst_valid}, 64'd0);
         check("rst_pc",    {32'd0, inst_pc},    64'd0);
      end
      check("rst_addr", {32'd0, mem_addr}, 64'd0);
      check("rst_data", {32'd0, inst_data}, 64'd0);

      // ---- 1/3: addresses 0..3 granted, then credit runs out ----
      reset = 1'b1;
      steps(5);
      check("bp_ngnt", 64'(gnt_log.size()), 64'd4);
      for (int i = 0; i < 4; i++) check("bp_addr", {32'd0, gnt_log[i]}, 64'(i));
      check("bp_req_off", {63'd0, mem_req}, 64'd0);

      // responses fill the queue while decode stalls
      rv_en = 1'b1;
      steps(4);
      check("bp_full_valid", {63'd0, inst_valid}, 64'd1);
      check("bp_full_head",  {inst_pc, inst_data}, {32'd0, XMASK});
      check("bp_full_req",   {63'd0, mem_req}, 64'd0);
      check("bp_full_ngnt",  64'(gnt_log.size()), 64'd4);
      check("bp_full_npop",  64'(pop_q.size()), 64'd0);

      // ---- 2/3: release decode, stream without bubbles ----
      inst_ready = 1'b1;
      steps(16);
      check("st_npop", 64'(pop_q.size()), 64'd16);
      for (int i = 0; i < 16; i++)
         check("st_word", pop_q[i], {32'(i), 32'(i) ^ XMASK});
      check("st_resume_addr", {32'd0, gnt_log[4]}, 64'd4);

      // ---- 4: redirect with three reads in flight ----
      gnt_en = 1'b0;
      steps(6);
      check("dr_pend",  64'(pend.size()), 64'd0);
      check("dr_valid", {63'd0, inst_valid}, 64'd0);
      pop_q.delete();
      gnt_log.delete();
      gnt_en = 1'b1;
      rv_en  = 1'b0;
      steps(3);
      check("rd_inflight", 64'(pend.size()), 64'd3);
      redirect_valid = 1'b1;
      redirect_addr  = 32'h0000_0100;
      step();
      redirect_valid = 1'b0;
      check("rd_req_low", {63'd0, s_req}, 64'd0);
      check("rd_flushed", {63'd0, inst_valid}, 64'd0);
      gnt_log.delete();
      rv_en = 1'b1;
      steps(3);
      check("rd_dropped_npop",  64'(pop_q.size()), 64'd0);
      check("rd_dropped_valid", {63'd0, inst_valid}, 64'd0);
      check("rd_new_addr",      {32'd0, gnt_log[0]}, 64'h100);
      steps(4);

      // ---- 4/5: redirect coincident with rvalid, to a wrapping address ----
      check("rw_rvalid_pending", {63'd0, pend.size() != 0}, 64'd1);
      redirect_valid = 1'b1;
      redirect_addr  = 32'hFFFF_FFFE;
      step();
      redirect_valid = 1'b0;
      check("rw_flushed", {63'd0, inst_valid}, 64'd0);
      check("rw_npop", 64'(pop_q.size()), 64'd3);
      for (int i = 0; i < 3; i++)
         check("rw_old_word", pop_q[i], {32'h100 + 32'(i), (32'h100 + 32'(i)) ^ XMASK});
      pop_q.delete();
      gnt_log.delete();
      steps(6);
      check("wr_npop", {63'd0, pop_q.size() >= 3}, 64'd1);
      check("wr_w0", pop_q[0], {32'hFFFF_FFFE, 32'h5A5A_FFFE});
      check("wr_w1", pop_q[1], {32'hFFFF_FFFF, 32'h5A5A_FFFF});
      check("wr_w2", pop_q[2], {32'h0000_0000, 32'hA5A5_0000});
      check("wr_a0", {32'd0, gnt_log[0]}, 64'hFFFF_FFFE);
      check("wr_a1", {32'd0, gnt_log[1]}, 64'hFFFF_FFFF);
      check("wr_a2", {32'd0, gnt_log[2]}, 64'h0000_0000);

      // ---- 6: response into an empty queue ----
      gnt_en = 1'b0;
      steps(6);
      check("by_empty", {63'd0, inst_valid}, 64'd0);
      pop_q.delete();
      gnt_en = 1'b1;
      rv_en  = 1'b0;
      step();
      gnt_en = 1'b0;
      rv_en  = 1'b1;
      step();
`ifdef IFQ_BYPASS_EN
      check("by_same_cycle", {63'd0, s_valid}, 64'd1);
      check("by_after",      {63'd0, inst_valid}, 64'd0);
`else
      check("by_same_cycle", {63'd0, s_valid}, 64'd0);
      check("by_after",      {63'd0, inst_valid}, 64'd1);
      check("by_head",       {inst_pc, inst_data}, {32'd4, 32'hA5A5_0004});
`endif
      step();
      check("by_npop", 64'(pop_q.size()), 64'd1);
      check("by_word", pop_q[0], {32'd4, 32'hA5A5_0004});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
